// File: rtl/mammal_intc.sv
// mammal_intc - prioritised interrupt controller for the mammal CPU.
//
// Collects up to NUM_SRC device requests. Each request is synchronised,
// latched into PENDING and qualified by MASK. The lowest-numbered enabled
// request is presented to the CPU on cpu_int. During the intack cycle the
// source index is driven onto the CPU read bus as the vector.
//
// Optional build macro: MAMMAL_INTC_EDGE_EN
//   defined   - pending[i] is set by a rising edge of the synchronised irq[i]
//               and holds until it is acknowledged or cleared by write-1.
//   undefined - pending[i] follows the synchronised irq[i] level every cycle.
//
// Ports
//   clk      in   single clock, all state on posedge
//   reset    in   synchronous, active-high
//   irq      in   [NUM_SRC] device requests, asynchronous to clk
//   address  in   [12] CPU word address
//   wr_data  in   [16] CPU write data
//   memwt    in   CPU write strobe
//   rd_data  out  [16] register readback, or vector while intack=1
//   rd_hit   out  rd_data overrides memory on the CPU data_in bus
//   cpu_int  out  interrupt request to the CPU (registered)
//   intack   in   interrupt acknowledge from the CPU
//
// Register map (word offset from MMIO_BASE)
//   +0 MASK    RW  enable bits [NUM_SRC-1:0]
//   +1 PENDING R / write-1-to-clear
//   +2 EOI     W   any write ends the in-service interrupt; reads 0
//   +3 STATUS  R   {insvc, 11'b0, idx[3:0]}
module mammal_intc #(
  parameter int          NUM_SRC   = 4,
  parameter logic [11:0] MMIO_BASE = 12'hFF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [11:0]        address,
  input  logic [15:0]        wr_data,
  input  logic               memwt,
  output logic [15:0]        rd_data,
  output logic               rd_hit,
  output logic               cpu_int,
  input  logic               intack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_INSVC  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               cpu_int_q;

  logic [11:0]        offset;
  logic               in_range;
  logic [1:0]         reg_sel;
  logic               mask_wr, pend_wr, eoi_wr;
  logic               do_ack;
  logic [NUM_SRC-1:0] req;
  logic [3:0]         first_idx;
  logic               insvc;

  // Only the low NUM_SRC data bits carry register content.
  logic               unused_wr_data;
  assign unused_wr_data = ^wr_data;

  // Address decode: subtracting the base lets a single range test cover
  // all four registers.
  assign offset   = address - MMIO_BASE;
  assign in_range = (offset[11:2] == 10'd0);
  assign reg_sel  = offset[1:0];
  assign mask_wr  = memwt && in_range && (reg_sel == 2'd0);
  assign pend_wr  = memwt && in_range && (reg_sel == 2'd1);
  assign eoi_wr   = memwt && in_range && (reg_sel == 2'd2);

  assign do_ack   = (state_q == S_ASSERT) && intack;
  assign req      = pending_q & mask_q;
  assign insvc    = (state_q == S_ASSERT) || (state_q == S_INSVC);

  assign mask_d   = mask_wr ? wr_data[NUM_SRC-1:0] : mask_q;

  // Lowest set bit wins: scan from the top so lower indices overwrite.
  always_comb begin
    first_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) first_idx = 4'(i);
    end
  end

`ifdef MAMMAL_INTC_EDGE_EN
  logic [NUM_SRC-1:0] sync3_q;
  logic [NUM_SRC-1:0] set_vec, clr_vec;

  always_comb begin
    set_vec = sync2_q & ~sync3_q;
    clr_vec = pend_wr ? wr_data[NUM_SRC-1:0] : '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (do_ack && (idx_q == 4'(i))) clr_vec[i] = 1'b1;
    end
    // A new edge in the same cycle as a clear keeps the bit set.
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) sync3_q <= '0;
    else       sync3_q <= sync2_q;
  end
`else
  // Level mode: pending mirrors the synchronised request, so clears and
  // acknowledges have nothing to hold on to.
  logic unused_w1c;
  assign unused_w1c = pend_wr;

  always_comb begin
    pending_d = sync2_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          idx_d   = first_idx;
          state_d = S_ASSERT;
        end
      end
      // idx stays frozen here; a mask change cannot withdraw the request.
      S_ASSERT: begin
        if (intack) state_d = S_INSVC;
      end
      S_INSVC: begin
        if (eoi_wr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      mask_q    <= '0;
      pending_q <= '0;
      cpu_int_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sync1_q   <= irq;
      sync2_q   <= sync1_q;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      cpu_int_q <= (state_d == S_ASSERT);
    end
  end

  assign cpu_int = cpu_int_q;

  // Vector has priority over register reads; intack outside ASSERT reads 0.
  always_comb begin
    rd_hit  = intack || (in_range && !memwt);
    rd_data = 16'h0000;
    if (intack) begin
      if (state_q == S_ASSERT) rd_data = {12'h000, idx_q};
    end else if (in_range && !memwt) begin
      case (reg_sel)
        2'd0:    rd_data = 16'(mask_q);
        2'd1:    rd_data = 16'(pending_q);
        2'd3:    rd_data = {insvc, 11'h000, (insvc ? idx_q : 4'd0)};
        default: rd_data = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_mammal_intc.sv
// Directed testbench for mammal_intc (NUM_SRC=4, MMIO_BASE=12'hFF0).
// Inputs change on the falling edge; outputs are sampled 1ns later,
// well away from the rising edge where the DUT updates.
module tb_mammal_intc;

  localparam logic [11:0] A_MASK = 12'hFF0;
  localparam logic [11:0] A_PEND = 12'hFF1;
  localparam logic [11:0] A_EOI  = 12'hFF2;
  localparam logic [11:0] A_STAT = 12'hFF3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic [11:0] address;
  logic [15:0] wr_data;
  logic        memwt;
  logic [15:0] rd_data;
  logic        rd_hit;
  logic        cpu_int;
  logic        intack;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  mammal_intc #(.NUM_SRC(4), .MMIO_BASE(12'hFF0)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .address (address),
    .wr_data (wr_data),
    .memwt   (memwt),
    .rd_data (rd_data),
    .rd_hit  (rd_hit),
    .cpu_int (cpu_int),
    .intack  (intack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    address = a;
    wr_data = d;
    memwt   = 1'b1;
    @(negedge clk);
    memwt   = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [15:0] d);
    address = a;
    memwt   = 1'b0;
    #1 d = rd_data;
  endtask

  // Bounded wait for cpu_int; returns the cycle count, or -1 on timeout.
  task automatic wait_int(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      #1;
      if (cpu_int === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic ack_pulse(input logic [15:0] exp_vec, input string tag);
    intack = 1'b1;
    #1;
    chk({tag, "_rdhit"}, 16'(rd_hit), 16'h0001);
    chk({tag, "_vec"}, rd_data, exp_vec);
    @(negedge clk);
    intack = 1'b0;
    #1;
    chk({tag, "_int_drop"}, 16'(cpu_int), 16'h0000);
  endtask

  logic [15:0] r;

  initial begin
    reset   = 1'b1;
    irq     = 4'h0;
    address = 12'h000;
    wr_data = 16'h0000;
    memwt   = 1'b0;
    intack  = 1'b0;
    cycles(3);
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_cpu_int", 16'(cpu_int), 16'h0000);
    chk("rst_rd_hit", 16'(rd_hit), 16'h0000);
    rd(A_MASK, r); chk("rst_mask", r, 16'h0000);
    rd(A_PEND, r); chk("rst_pend", r, 16'h0000);
    rd(A_STAT, r); chk("rst_status", r, 16'h0000);

    // 1: single enabled source
    @(negedge clk);
    wr(A_MASK, 16'h0005);
    irq = 4'b0100;
    wait_int(8, cyc);
    chk("t1_latency_ok", 16'((cyc >= 1) && (cyc <= 4)), 16'h0001);
    rd(A_STAT, r); chk("t1_status", r, 16'h8002);
    rd(A_PEND, r); chk("t1_pending", r, 16'h0004);

    // 2: acknowledge, vector, EOI
    ack_pulse(16'h0002, "t2");
    rd(A_STAT, r); chk("t2_status_insvc", r, 16'h8002);
    irq = 4'b0000;
    cycles(4);
    wr(A_EOI, 16'h1234);
    rd(A_STAT, r); chk("t2_status_eoi", r, 16'h0000);
    rd(A_EOI, r); chk("t2_eoi_reads0", r, 16'h0000);
    cycles(4);
    #1 chk("t2_no_refire", 16'(cpu_int), 16'h0000);
    intack = 1'b1;
    #1;
    chk("t2_idle_ack_hit", 16'(rd_hit), 16'h0001);
    chk("t2_idle_ack_data", rd_data, 16'h0000);
    @(negedge clk);
    intack = 1'b0;
    #1 chk("t2_idle_ack_noint", 16'(cpu_int), 16'h0000);

    // 3: priority between two sources, mask write above NUM_SRC ignored
    irq = 4'b1010;
    cycles(5);
    #1 chk("t3_masked_noint", 16'(cpu_int), 16'h0000);
    wr(A_MASK, 16'hFFFF);
    rd(A_MASK, r); chk("t3_mask_width", r, 16'h000F);
    wait_int(4, cyc);
    chk("t3_first_found", 16'(cyc > 0), 16'h0001);
    rd(A_STAT, r); chk("t3_status_idx1", r, 16'h8001);
    ack_pulse(16'h0001, "t3a");
    irq = 4'b1000;
    cycles(4);
    wr(A_EOI, 16'h0000);
    wait_int(4, cyc);
    chk("t3_second_found", 16'(cyc > 0), 16'h0001);
    rd(A_STAT, r); chk("t3_status_idx3", r, 16'h8003);
    ack_pulse(16'h0003, "t3b");
    irq = 4'b0000;
    cycles(4);
    wr(A_EOI, 16'h0000);
    rd(A_STAT, r); chk("t3_status_end", r, 16'h0000);

    // 4: masked request pends without interrupt, then unmasked
    wr(A_MASK, 16'h0000);
    irq = 4'b0001;
    cycles(5);
    #1 chk("t4_masked_noint", 16'(cpu_int), 16'h0000);
    rd(A_PEND, r); chk("t4_pending", r, 16'h0001);
    wr(A_MASK, 16'h0001);
    wait_int(4, cyc);
    chk("t4_int_found", 16'(cyc > 0), 16'h0001);
    rd(A_STAT, r); chk("t4_status", r, 16'h8000);
    wr(A_MASK, 16'h0000);
    #1 chk("t4_mask_no_withdraw", 16'(cpu_int), 16'h0001);

    // 6: reset while in ASSERT
    reset   = 1'b1;
    address = 12'h000;
    @(negedge clk);
    #1;
    chk("t6_cpu_int", 16'(cpu_int), 16'h0000);
    chk("t6_rd_hit", 16'(rd_hit), 16'h0000);
    rd(A_MASK, r); chk("t6_mask", r, 16'h0000);
    rd(A_PEND, r); chk("t6_pend", r, 16'h0000);
    rd(A_STAT, r); chk("t6_status", r, 16'h0000);
    irq = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    cycles(2);

    // 5: write-1-to-clear on PENDING
`ifdef MAMMAL_INTC_EDGE_EN
    irq = 4'b0001;
    @(negedge clk);
    irq = 4'b0000;
    cycles(4);
    rd(A_PEND, r); chk("t5_edge_pend", r, 16'h0001);
    wr(A_PEND, 16'h0001);
    rd(A_PEND, r); chk("t5_edge_cleared", r, 16'h0000);
`else
    irq = 4'b0001;
    cycles(4);
    rd(A_PEND, r); chk("t5_level_pend", r, 16'h0001);
    wr(A_PEND, 16'h0001);
    @(negedge clk);
    rd(A_PEND, r); chk("t5_level_held", r, 16'h0001);
    irq = 4'b0000;
`endif
    cycles(2);
    #1 chk("t5_no_int_mask0", 16'(cpu_int), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
